// File: rtl/memsnoop_ctrl.sv
// memsnoop_ctrl
// Patch-rule controller for the main-bus snoop/filter. It holds a table of
// address/value rules and matches every bus access against them. On a hit the
// data byte is overridden. It also counts hits per rule. Configuration
// traffic from the host is only accepted while the bus is quiet, so the table
// never changes during an access.
//
// Ports
//   clk, rst_n            core clock, synchronous active-low reset
//   RD_n, WR_n            bus strobes (active-low)
//   addr, data_in         live bus address and byte
//   data_out, hit,        filtered byte, match flag and winning rule index
//   hit_idx
//   cfg_valid/cfg_ready   config handshake
//   cfg_op, cfg_idx,      op (WRITE/ENABLE/DISABLE/CLEAR_ALL), target rule,
//   cfg_addr, cfg_data,   and the rule payload used by WRITE
//   cfg_mode
//   stat_idx, stat_count, status read-out for one rule
//   stat_en
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | normal matching; config ops accepted when the bus is quiet
// CLEAR  | sweeping the table one rule per cycle; matching suppressed
module memsnoop_ctrl #(
    parameter int ENTRIES = 8,
    parameter int IDXW    = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RD_n,
    input  logic            WR_n,
    input  logic [23:0]     addr,
    input  logic [7:0]      data_in,
    output logic [7:0]      data_out,
    output logic            hit,
    output logic [IDXW-1:0] hit_idx,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [1:0]      cfg_op,
    input  logic [IDXW-1:0] cfg_idx,
    input  logic [23:0]     cfg_addr,
    input  logic [7:0]      cfg_data,
    input  logic [1:0]      cfg_mode,
    input  logic [IDXW-1:0] stat_idx,
    output logic [7:0]      stat_count,
    output logic            stat_en
);

    localparam logic [1:0] OP_WRITE   = 2'd0;
    localparam logic [1:0] OP_ENABLE  = 2'd1;
    localparam logic [1:0] OP_DISABLE = 2'd2;
    localparam logic [1:0] OP_CLEAR   = 2'd3;

    localparam logic [1:0] M_PATCH_RD   = 2'd0;
    localparam logic [1:0] M_PATCH_WR   = 2'd1;
    localparam logic [1:0] M_ONESHOT_RD = 2'd2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t          state;
    logic            act_q;
    logic [IDXW-1:0] sweep;
    logic            os_pend;
    logic [IDXW-1:0] os_idx;

    logic            r_en    [ENTRIES];
    logic [23:0]     r_addr  [ENTRIES];
    logic [7:0]      r_data  [ENTRIES];
    logic [1:0]      r_mode  [ENTRIES];
    logic [7:0]      r_count [ENTRIES];

    logic rd_act;
    logic wr_act;
    logic active;
    logic access_start;
    logic access_end;

    assign rd_act       = ~RD_n;
    assign wr_act       = ~WR_n;
    assign active       = rd_act | wr_act;
    assign access_start = active & ~act_q;
    assign access_end   = ~active & act_q;

    assign cfg_ready  = (state == S_IDLE) & ~active & ~act_q & rst_n;
    assign stat_count = r_count[stat_idx];
    assign stat_en    = r_en[stat_idx];

    function automatic logic mode_ok(input logic [1:0] m, input logic rd, input logic wr);
        case (m)
            M_PATCH_RD, M_ONESHOT_RD: mode_ok = rd;
            M_PATCH_WR:               mode_ok = wr;
            default:                  mode_ok = rd | wr;   // FREEZE
        endcase
    endfunction

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        data_out = data_in;
        if (rst_n && state == S_IDLE) begin
            for (int i = ENTRIES - 1; i >= 0; i--) begin
                if (r_en[i] && r_addr[i] == addr && mode_ok(r_mode[i], rd_act, wr_act)) begin
                    hit      = 1'b1;
                    hit_idx  = IDXW'(i);
                    data_out = r_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            act_q   <= 1'b0;
            sweep   <= '0;
            os_pend <= 1'b0;
            os_idx  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_en[i]    <= 1'b0;
                r_addr[i]  <= '0;
                r_data[i]  <= '0;
                r_mode[i]  <= '0;
                r_count[i] <= '0;
            end
        end else begin
            act_q <= active;

            // Counted once per access, on its first cycle only.
            if (access_start && hit) begin
                if (r_count[hit_idx] != 8'hFF)
                    r_count[hit_idx] <= r_count[hit_idx] + 8'd1;
                if (r_mode[hit_idx] == M_ONESHOT_RD) begin
                    os_pend <= 1'b1;
                    os_idx  <= hit_idx;
                end
            end

            // One-shot rule stays live for the whole access, retires at its end.
            if (access_end && os_pend) begin
                r_en[os_idx] <= 1'b0;
                os_pend      <= 1'b0;
            end

            // Config ops cannot overlap access edges: cfg_ready is low whenever
            // active or act_q, so the writes below never collide with the above.
            case (state)
                S_IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        case (cfg_op)
                            OP_WRITE: begin
                                r_en[cfg_idx]    <= 1'b1;
                                r_addr[cfg_idx]  <= cfg_addr;
                                r_data[cfg_idx]  <= cfg_data;
                                r_mode[cfg_idx]  <= cfg_mode;
                                r_count[cfg_idx] <= '0;
                            end
                            OP_ENABLE:  r_en[cfg_idx] <= 1'b1;
                            OP_DISABLE: r_en[cfg_idx] <= 1'b0;
                            OP_CLEAR: begin
                                state <= S_CLEAR;
                                sweep <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CLEAR: begin
                    r_en[sweep]    <= 1'b0;
                    r_addr[sweep]  <= '0;
                    r_data[sweep]  <= '0;
                    r_mode[sweep]  <= '0;
                    r_count[sweep] <= '0;
                    if (sweep == IDXW'(ENTRIES - 1)) begin
                        state <= S_IDLE;
                        sweep <= '0;
                    end else begin
                        sweep <= sweep + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memsnoop_ctrl.sv
// Directed bench for memsnoop_ctrl: reset values, priority, one-shot
// retirement, count saturation and the CLEAR_ALL sweep timing.
module tb_memsnoop_ctrl;

    localparam int ENTRIES = 8;
    localparam int IDXW    = 3;

    localparam logic [1:0] OP_WRITE   = 2'd0;
    localparam logic [1:0] OP_DISABLE = 2'd2;
    localparam logic [1:0] OP_CLEAR   = 2'd3;
    localparam logic [1:0] M_PATCH_RD   = 2'd0;
    localparam logic [1:0] M_PATCH_WR   = 2'd1;
    localparam logic [1:0] M_ONESHOT_RD = 2'd2;
    localparam logic [1:0] M_FREEZE     = 2'd3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            RD_n = 1'b1;
    logic            WR_n = 1'b1;
    logic [23:0]     addr = '0;
    logic [7:0]      data_in = 8'h5A;
    logic [7:0]      data_out;
    logic            hit;
    logic [IDXW-1:0] hit_idx;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [1:0]      cfg_op = '0;
    logic [IDXW-1:0] cfg_idx = '0;
    logic [23:0]     cfg_addr = '0;
    logic [7:0]      cfg_data = '0;
    logic [1:0]      cfg_mode = '0;
    logic [IDXW-1:0] stat_idx = '0;
    logic [7:0]      stat_count;
    logic            stat_en;

    int vectors = 0;
    int miscompares = 0;

    memsnoop_ctrl #(.ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst_n(rst_n), .RD_n(RD_n), .WR_n(WR_n),
        .addr(addr), .data_in(data_in), .data_out(data_out),
        .hit(hit), .hit_idx(hit_idx),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op),
        .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_mode(cfg_mode), .stat_idx(stat_idx),
        .stat_count(stat_count), .stat_en(stat_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] op, input logic [IDXW-1:0] idx,
                       input logic [23:0] a, input logic [7:0] d, input logic [1:0] m);
        cfg_valid = 1'b1; cfg_op = op; cfg_idx = idx;
        cfg_addr = a; cfg_data = d; cfg_mode = m;
        #1;
        chk("cfg_ready_at_request", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        #1;
    endtask

    task automatic bus_on(input bit rd, input logic [23:0] a, input logic [7:0] d);
        RD_n = ~rd; WR_n = rd; addr = a; data_in = d;
        #1;
    endtask

    task automatic bus_off();
        RD_n = 1'b1; WR_n = 1'b1;
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        repeat (4) tick();
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_hit", hit, 0);
        chk("rst_data_out", data_out, 8'h5A);
        rst_n = 1'b1;
        #1;
        chk("idle_cfg_ready", cfg_ready, 1);
        chk("idle_hit", hit, 0);
        chk("idle_hit_idx", hit_idx, 0);
        chk("idle_data_out", data_out, 8'h5A);
        for (int i = 0; i < ENTRIES; i++) begin
            stat_idx = IDXW'(i);
            #1;
            chk("idle_stat_count", stat_count, 0);
            chk("idle_stat_en", stat_en, 0);
        end
        data_in = 8'h33;
        #1;
        chk("idle_track", data_out, 8'h33);

        // PATCH_RD on rule 0, 3-cycle read counts once
        cfg(OP_WRITE, 0, 24'h000085, 8'h01, M_PATCH_RD);
        stat_idx = 0;
        bus_on(1, 24'h000085, 8'h00);
        for (int c = 0; c < 3; c++) begin
            chk("rd0_data_out", data_out, 8'h01);
            chk("rd0_hit", hit, 1);
            chk("rd0_hit_idx", hit_idx, 0);
            chk("rd0_count", stat_count, (c == 0) ? 0 : 1);
            tick();
        end
        bus_off();
        tick();
        chk("rd0_count_after", stat_count, 1);
        bus_on(0, 24'h000085, 8'h44);
        chk("wr0_passthru", data_out, 8'h44);
        chk("wr0_hit", hit, 0);
        tick();
        bus_off();
        tick();

        // Priority between rules 2 and 5
        cfg(OP_WRITE, 2, 24'h7E0019, 8'h03, M_PATCH_RD);
        cfg(OP_WRITE, 5, 24'h7E0019, 8'h07, M_PATCH_RD);
        bus_on(1, 24'h7E0019, 8'hAA);
        chk("prio_data_out", data_out, 8'h03);
        chk("prio_hit_idx", hit_idx, 2);
        tick();
        bus_off();
        tick();
        cfg(OP_DISABLE, 2, 24'h0, 8'h0, 2'd0);
        stat_idx = 2;
        #1;
        chk("dis2_stat_en", stat_en, 0);
        bus_on(1, 24'h7E0019, 8'hAA);
        chk("dis2_data_out", data_out, 8'h07);
        chk("dis2_hit_idx", hit_idx, 5);
        tick();
        bus_off();
        tick();

        // One-shot rule 1
        cfg(OP_WRITE, 1, 24'h000019, 8'h02, M_ONESHOT_RD);
        stat_idx = 1;
        bus_on(1, 24'h000019, 8'h55);
        chk("os_data_out_c1", data_out, 8'h02);
        chk("os_hit_idx", hit_idx, 1);
        tick();
        chk("os_data_out_c2", data_out, 8'h02);
        tick();
        bus_off();
        chk("os_en_at_end", stat_en, 1);
        tick();
        chk("os_en_after_end", stat_en, 0);
        chk("os_count", stat_count, 1);
        bus_on(1, 24'h000019, 8'h99);
        chk("os_second_passthru", data_out, 8'h99);
        chk("os_second_hit", hit, 0);
        tick();
        bus_off();
        tick();

        // FREEZE rule 3, 300 accesses of mixed length and direction
        cfg(OP_WRITE, 3, 24'h001000, 8'hEE, M_FREEZE);
        stat_idx = 3;
        for (int k = 0; k < 300; k++) begin
            bus_on(k % 2 == 0, 24'h001000, 8'h10);
            if (k == 0) chk("frz_rd_data_out", data_out, 8'hEE);
            if (k == 1) chk("frz_wr_data_out", data_out, 8'hEE);
            repeat (1 + k % 3) tick();
            bus_off();
            tick();
            if (k == 253) chk("frz_count_254", stat_count, 254);
            if (k == 254) chk("frz_count_255", stat_count, 255);
        end
        chk("frz_count_sat", stat_count, 255);

        // CLEAR_ALL with rules 0,3,4,5 enabled
        cfg(OP_WRITE, 4, 24'h002000, 8'h44, M_PATCH_WR);
        cfg(OP_CLEAR, 0, 24'h0, 8'h0, 2'd0);
        for (int c = 1; c <= 8; c++) begin
            if (c == 5) bus_on(1, 24'h000085, 8'h11);
            if (c == 7) bus_off();
            chk("clr_cfg_ready_low", cfg_ready, 0);
            if (c == 5 || c == 6) begin
                chk("clr_passthru", data_out, 8'h11);
                chk("clr_hit", hit, 0);
            end
            tick();
        end
        chk("clr_cfg_ready_back", cfg_ready, 1);
        for (int i = 0; i < ENTRIES; i++) begin
            stat_idx = IDXW'(i);
            #1;
            chk("clr_stat_count", stat_count, 0);
            chk("clr_stat_en", stat_en, 0);
        end

        // Reset aborts a CLEAR sweep
        cfg(OP_CLEAR, 0, 24'h0, 8'h0, 2'd0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rst_mid_clr_ready", cfg_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_clr_idle", cfg_ready, 1);

        // Reset aborts an access
        cfg(OP_WRITE, 0, 24'h000085, 8'h01, M_PATCH_RD);
        stat_idx = 0;
        bus_on(1, 24'h000085, 8'h22);
        chk("rst_acc_hit_before", hit, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_acc_hit", hit, 0);
        chk("rst_acc_data_out", data_out, 8'h22);
        tick();
        rst_n = 1'b1;
        bus_off();
        chk("rst_acc_ready", cfg_ready, 1);
        chk("rst_acc_en", stat_en, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
